// File: rtl/id_ex_stage_if.sv
// Decode-to-execute handshake bundle: ID operands in, registered EX copies,
// flush / back-pressure / write-back controls and stall/bubble status out.
interface id_ex_stage_if #(
    parameter int CTRL_W = 16
);
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [31:0]       id_rd1;
    logic [31:0]       id_rd2;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;

    logic              flush;
    logic              ex_ready;

    logic              wb_wr;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_wd;

    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [31:0]       ex_rd1;
    logic [31:0]       ex_rd2;
    logic [31:0]       ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;

    logic              stall_if_id;
    logic [31:0]       bubble_cnt;

    // master: upstream decode / EX / write-back side; slave: the pipeline register
    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_rd1, id_rd2, id_imm, id_ctrl, flush, ex_ready, wb_wr, wb_rd, wb_wd,
        input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_ctrl,
               stall_if_id, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_rd1, id_rd2, id_imm, id_ctrl, flush, ex_ready, wb_wr, wb_rd, wb_wd,
        output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_ctrl,
               stall_if_id, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and EX back-pressure.
// Optional write-back bypass into captured/held operands: ID_EX_WB_BYPASS_EN.
module id_ex_stage #(
    parameter int CTRL_W = 16
) (
    input  logic          clk,
    input  logic          rstn,
    id_ex_stage_if.slave  bus
);
    logic        hazard;
    logic        rs1_match;
    logic        rs2_match;
    logic [31:0] cap_rd1;
    logic [31:0] cap_rd2;
    logic [31:0] hold_rd1;
    logic [31:0] hold_rd2;

    assign rs1_match = bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd);
    assign rs2_match = bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd);

    assign hazard = bus.ex_valid && bus.ex_ctrl[1] && (bus.ex_rd != 5'd0) &&
                    bus.id_valid && (rs1_match || rs2_match);

    // Reset gating keeps the stall request quiet while the stage is held in reset.
    assign bus.stall_if_id = rstn && (hazard || !bus.ex_ready) && !bus.flush;

`ifdef ID_EX_WB_BYPASS_EN
    logic wb_hit;
    assign wb_hit = bus.wb_wr && (bus.wb_rd != 5'd0);

    always_comb begin
        cap_rd1  = bus.id_rd1;
        cap_rd2  = bus.id_rd2;
        hold_rd1 = bus.ex_rd1;
        hold_rd2 = bus.ex_rd2;
        if (wb_hit && (bus.wb_rd == bus.id_rs1)) cap_rd1  = bus.wb_wd;
        if (wb_hit && (bus.wb_rd == bus.id_rs2)) cap_rd2  = bus.wb_wd;
        if (wb_hit && (bus.wb_rd == bus.ex_rs1)) hold_rd1 = bus.wb_wd;
        if (wb_hit && (bus.wb_rd == bus.ex_rs2)) hold_rd2 = bus.wb_wd;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_wr, bus.wb_rd, bus.wb_wd};

    always_comb begin
        cap_rd1  = bus.id_rd1;
        cap_rd2  = bus.id_rd2;
        hold_rd1 = bus.ex_rd1;
        hold_rd2 = bus.ex_rd2;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_pc      <= '0;
            bus.ex_rs1     <= '0;
            bus.ex_rs2     <= '0;
            bus.ex_rd      <= '0;
            bus.ex_rd1     <= '0;
            bus.ex_rd2     <= '0;
            bus.ex_imm     <= '0;
            bus.ex_ctrl    <= '0;
            bus.bubble_cnt <= '0;
        end else if (bus.flush) begin
            // Killed slot: fields follow ID but control is cleared with the valid bit.
            bus.ex_valid <= 1'b0;
            bus.ex_pc    <= bus.id_pc;
            bus.ex_rs1   <= bus.id_rs1;
            bus.ex_rs2   <= bus.id_rs2;
            bus.ex_rd    <= bus.id_rd;
            bus.ex_rd1   <= cap_rd1;
            bus.ex_rd2   <= cap_rd2;
            bus.ex_imm   <= bus.id_imm;
            bus.ex_ctrl  <= '0;
        end else if (!bus.ex_ready) begin
            bus.ex_rd1 <= hold_rd1;
            bus.ex_rd2 <= hold_rd2;
        end else if (hazard) begin
            bus.ex_valid <= 1'b0;
            bus.ex_ctrl  <= '0;
            if (bus.bubble_cnt != 32'hFFFF_FFFF)
                bus.bubble_cnt <= bus.bubble_cnt + 32'd1;
        end else begin
            bus.ex_valid <= bus.id_valid;
            bus.ex_pc    <= bus.id_pc;
            bus.ex_rs1   <= bus.id_rs1;
            bus.ex_rs2   <= bus.id_rs2;
            bus.ex_rd    <= bus.id_rd;
            bus.ex_rd1   <= cap_rd1;
            bus.ex_rd2   <= cap_rd2;
            bus.ex_imm   <= bus.id_imm;
            bus.ex_ctrl  <= bus.id_valid ? bus.id_ctrl : '0;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; bypass expectations follow ID_EX_WB_BYPASS_EN.
module tb_id_ex_stage;
    logic clk;
    logic rstn;
    int   total;
    int   bad;

    id_ex_stage_if #(.CTRL_W(16)) bus ();

    id_ex_stage #(.CTRL_W(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_id(input logic v, input logic [31:0] pc,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic u1, input logic u2,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic [15:0] ctrl);
        bus.id_valid    = v;
        bus.id_pc       = pc;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_uses_rs1 = u1;
        bus.id_uses_rs2 = u2;
        bus.id_rd1      = d1;
        bus.id_rd2      = d2;
        bus.id_imm      = ~pc;
        bus.id_ctrl     = ctrl;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.flush = 1'b0; bus.ex_ready = 1'b1;
        bus.wb_wr = 1'b0; bus.wb_rd = '0; bus.wb_wd = '0;
        drive_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
        #12;
        total++;
        if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h0 || bus.ex_ctrl !== 16'h0 ||
            bus.bubble_cnt !== 32'h0 || bus.stall_if_id !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid=%b pc=%h ctrl=%h cnt=%0d stall=%b, need all 0",
                     bus.ex_valid, bus.ex_pc, bus.ex_ctrl, bus.bubble_cnt, bus.stall_if_id);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_capture();
        @(negedge clk);
        drive_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h11, 32'h22, 16'h0001);
        #1;
        total++;
        if (bus.stall_if_id !== 1'b0) begin
            bad++;
            $display("FAIL capture_stall: got %b need 0", bus.stall_if_id);
        end
        @(posedge clk); #1;
        total++;
        if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h100 || bus.ex_rd1 !== 32'h11 ||
            bus.ex_rd2 !== 32'h22 || bus.ex_rd !== 5'd3 || bus.ex_imm !== ~32'h100 ||
            bus.ex_ctrl !== 16'h0001) begin
            bad++;
            $display("FAIL capture_fields: valid=%b pc=%h rd1=%h rd2=%h rd=%0d imm=%h ctrl=%h, need 1 100 11 22 3 %h 0001",
                     bus.ex_valid, bus.ex_pc, bus.ex_rd1, bus.ex_rd2, bus.ex_rd, bus.ex_imm,
                     bus.ex_ctrl, ~32'h100);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        drive_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 16'h0003);
        @(posedge clk);
        @(negedge clk);
        drive_id(1'b1, 32'h204, 5'd1, 5'd5, 5'd6, 1'b1, 1'b1, 32'h7, 32'h8, 16'h0001);
        #1;
        total++;
        if (bus.stall_if_id !== 1'b1) begin
            bad++;
            $display("FAIL load_use_stall: got %b need 1", bus.stall_if_id);
        end
        @(posedge clk); #1;
        total++;
        if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 16'h0 || bus.bubble_cnt !== 32'd1) begin
            bad++;
            $display("FAIL load_use_bubble: valid=%b ctrl=%h cnt=%0d, need 0 0000 1",
                     bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt);
        end
        total++;
        if (bus.stall_if_id !== 1'b0) begin
            bad++;
            $display("FAIL load_use_release: stall=%b need 0", bus.stall_if_id);
        end
        @(posedge clk); #1;
        total++;
        if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h204 || bus.ex_ctrl !== 16'h0001 ||
            bus.bubble_cnt !== 32'd1) begin
            bad++;
            $display("FAIL load_use_capture: valid=%b pc=%h ctrl=%h cnt=%0d, need 1 204 0001 1",
                     bus.ex_valid, bus.ex_pc, bus.ex_ctrl, bus.bubble_cnt);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive_id(1'b1, 32'h300, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 16'h0003);
        @(posedge clk);
        @(negedge clk);
        drive_id(1'b1, 32'h304, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'h1, 32'h2, 16'h0001);
        bus.flush = 1'b1;
        #1;
        total++;
        if (bus.stall_if_id !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall: got %b need 0", bus.stall_if_id);
        end
        @(posedge clk); #1;
        total++;
        if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 16'h0 || bus.bubble_cnt !== 32'd1) begin
            bad++;
            $display("FAIL flush_kill: valid=%b ctrl=%h cnt=%0d, need 0 0000 1",
                     bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt);
        end
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    task automatic test_back_pressure();
        drive_id(1'b1, 32'h400, 5'd7, 5'd8, 5'd9, 1'b1, 1'b1, 32'h44, 32'h45, 16'h00A1);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.ex_ready = 1'b0;
            drive_id(1'b1, 32'h500 + 32'(4 * i), 5'd2, 5'd3, 5'd4, 1'b1, 1'b1,
                     32'h60 + 32'(i), 32'h70, 16'h0001);
            #1;
            total++;
            if (bus.stall_if_id !== 1'b1) begin
                bad++;
                $display("FAIL hold_stall[%0d]: got %b need 1", i, bus.stall_if_id);
            end
            @(posedge clk); #1;
            total++;
            if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h400 || bus.ex_rd1 !== 32'h44 ||
                bus.ex_rs1 !== 5'd7 || bus.ex_ctrl !== 16'h00A1) begin
                bad++;
                $display("FAIL hold_fields[%0d]: valid=%b pc=%h rd1=%h rs1=%0d ctrl=%h, need 1 400 44 7 00a1",
                         i, bus.ex_valid, bus.ex_pc, bus.ex_rd1, bus.ex_rs1, bus.ex_ctrl);
            end
        end
        @(negedge clk);
        bus.ex_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.ex_pc !== 32'h508 || bus.ex_rd1 !== 32'h62) begin
            bad++;
            $display("FAIL hold_release: pc=%h rd1=%h need 508 62", bus.ex_pc, bus.ex_rd1);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_hold;
        logic [31:0] exp_rd2;
`ifdef ID_EX_WB_BYPASS_EN
        exp_hold = 32'hDEAD;
        exp_rd2  = 32'h99;
`else
        exp_hold = 32'h44;
        exp_rd2  = 32'h22;
`endif
        @(negedge clk);
        drive_id(1'b1, 32'h600, 5'd7, 5'd8, 5'd1, 1'b1, 1'b1, 32'h44, 32'h45, 16'h0001);
        @(posedge clk);
        @(negedge clk);
        bus.ex_ready = 1'b0;
        drive_id(1'b1, 32'h604, 5'd3, 5'd4, 5'd2, 1'b1, 1'b1, 32'h33, 32'h34, 16'h0001);
        bus.wb_wr = 1'b1; bus.wb_rd = 5'd7; bus.wb_wd = 32'hDEAD;
        @(posedge clk); #1;
        total++;
        if (bus.ex_rd1 !== exp_hold || bus.ex_rd2 !== 32'h45) begin
            bad++;
            $display("FAIL bypass_hold: rd1=%h rd2=%h need %h 45", bus.ex_rd1, bus.ex_rd2, exp_hold);
        end
        @(negedge clk);
        bus.ex_ready = 1'b1;
        drive_id(1'b1, 32'h608, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 32'h55, 32'h56, 16'h0001);
        bus.wb_wr = 1'b1; bus.wb_rd = 5'd0; bus.wb_wd = 32'hBEEF;
        @(posedge clk); #1;
        total++;
        if (bus.ex_rd1 !== 32'h55 || bus.ex_rd2 !== 32'h56) begin
            bad++;
            $display("FAIL bypass_x0: rd1=%h rd2=%h need 55 56", bus.ex_rd1, bus.ex_rd2);
        end
        @(negedge clk);
        drive_id(1'b1, 32'h60C, 5'd4, 5'd9, 5'd2, 1'b1, 1'b1, 32'h66, 32'h22, 16'h0001);
        bus.wb_wr = 1'b1; bus.wb_rd = 5'd9; bus.wb_wd = 32'h99;
        @(posedge clk); #1;
        total++;
        if (bus.ex_rd1 !== 32'h66 || bus.ex_rd2 !== exp_rd2) begin
            bad++;
            $display("FAIL bypass_capture_rs2: rd1=%h rd2=%h need 66 %h", bus.ex_rd1, bus.ex_rd2, exp_rd2);
        end
        @(negedge clk);
        bus.wb_wr = 1'b0;
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        bus.ex_ready = 1'b0;
        #1;
        total++;
        if (bus.ex_valid !== 1'b1 || bus.bubble_cnt !== 32'd1) begin
            bad++;
            $display("FAIL pre_reset: valid=%b cnt=%0d need 1 1", bus.ex_valid, bus.bubble_cnt);
        end
        rstn = 1'b0;
        #1;
        total++;
        if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h0 || bus.ex_rd1 !== 32'h0 ||
            bus.ex_ctrl !== 16'h0 || bus.bubble_cnt !== 32'h0 || bus.stall_if_id !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: valid=%b pc=%h rd1=%h ctrl=%h cnt=%0d stall=%b, need all 0",
                     bus.ex_valid, bus.ex_pc, bus.ex_rd1, bus.ex_ctrl, bus.bubble_cnt, bus.stall_if_id);
        end
        @(negedge clk);
        rstn = 1'b1;
        bus.ex_ready = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_capture();
        test_load_use();
        test_flush();
        test_back_pressure();
        test_bypass();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end
endmodule
